ram_readback_checker: RTL

Downstream consumer of the RAM test-pattern stage: it watches the RAM read enable, address and read-data buses and checks every read against the pattern the writer stores, where the word at address a is {3'b000, a}. It tracks read passes, counts mismatches and latches the first failing address and data. It publishes a per-pass verdict for the lock's self-test and status logic.

---
 rtl/ram_readback_checker.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ram_readback_checker.sv
// Read-back checker for the RAM test pattern: the word at address a must be {3'b000, a}.
// Tracks passes over addresses 0..31, counts failing beats and latches the first failure.
module ram_readback_checker #(
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 6
) (
  input  logic             clk_50M,
  input  logic             RST_N,
  input  logic             rden,
  input  logic [4:0]       address,
  input  logic [7:0]       rddata,
  input  logic             clear,
  output logic             mismatch,
  output logic             done,
  output logic             pass_ok,
  output logic             sticky_fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       pass_cnt,
  output logic [4:0]       first_err_addr,
  output logic [7:0]       first_err_data
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CHECK = 1'b1;

  logic              state;
  logic [RD_LAT-1:0] vld_pipe;
  logic [4:0]        adr_pipe [RD_LAT];
  logic [4:0]        seq;
  logic              pass_bad;

  logic       due;
  logic [4:0] due_addr;
  logic [7:0] exp_data;
  logic       data_bad;
  logic       beat_fail;
  logic       check_beat;

  // Address/valid delay line aligning each sampled read with its returned data.
  always_ff @(posedge clk_50M or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) adr_pipe[i] <= '0;
    end else if (clear) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rden;
      adr_pipe[0] <= address;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        adr_pipe[i] <= adr_pipe[i-1];
      end
    end
  end

  always_comb begin
    due        = vld_pipe[RD_LAT-1];
    due_addr   = adr_pipe[RD_LAT-1];
    exp_data   = {3'b000, due_addr};
    data_bad   = (rddata != exp_data);
    // The pass-opening address-0 beat only has its data checked.
    beat_fail  = (state == ST_IDLE) ? data_bad : (data_bad || (due_addr != seq));
    check_beat = due && ((state == ST_CHECK) || (due_addr == 5'd0));
  end

  always_ff @(posedge clk_50M or negedge RST_N) begin
    if (!RST_N) begin
      state          <= ST_IDLE;
      seq            <= '0;
      pass_bad       <= 1'b0;
      mismatch       <= 1'b0;
      done           <= 1'b0;
      pass_ok        <= 1'b0;
      sticky_fail    <= 1'b0;
      err_cnt        <= '0;
      pass_cnt       <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else begin
      mismatch <= 1'b0;
      done     <= 1'b0;
      if (clear) begin
        state          <= ST_IDLE;
        seq            <= '0;
        pass_bad       <= 1'b0;
        pass_ok        <= 1'b0;
        sticky_fail    <= 1'b0;
        err_cnt        <= '0;
        pass_cnt       <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
      end else if (check_beat) begin
        if (beat_fail) begin
          mismatch    <= 1'b1;
          sticky_fail <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          // sticky_fail low means no failure yet since reset or clear
          if (!sticky_fail) begin
            first_err_addr <= due_addr;
            first_err_data <= rddata;
          end
        end
        seq <= due_addr + 5'd1;
        if (state == ST_IDLE) begin
          pass_bad <= beat_fail;
          state    <= ST_CHECK;
        end else begin
          pass_bad <= pass_bad | beat_fail;
          if (due_addr == 5'd31) begin
            done     <= 1'b1;
            pass_ok  <= ~(pass_bad | beat_fail);
            pass_cnt <= pass_cnt + 8'd1;
            state    <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
